// File: rtl/mux_sel_scanner_pkg.sv
// Shared types and constants for the mux select scanner and its helpers.
package mux_sel_scanner_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int NUM_IN = 7;
    localparam int SEL_W  = 3;

endpackage

// File: rtl/rate_tick.sv
// Enable-gated rate divider: asserts tick on every DIV-th enabled clock.
module rate_tick #(
    parameter  int DIV   = 25_000_000,
    localparam int CNT_W = $clog2(DIV) + 1
) (
    input  logic clk,
    input  logic srst,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(DIV - 1);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;
    logic             at_last;

    assign at_last = (count_reg == LAST);
    assign tick    = en && at_last;

    // Wraps at DIV-1 so the count never runs past the terminal value.
    always_comb begin
        count_next = count_reg;
        if (clr) begin
            count_next = '0;
        end else if (en) begin
            count_next = at_last ? '0 : count_reg + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/mux_sel_scanner.sv
// Walks the 7-to-1 mux select through every input, one step per DIV clocks,
// and gathers the returned bits into a parallel word for the status display.
module mux_sel_scanner
    import mux_sel_scanner_pkg::*;
#(
    parameter int DIV = 25_000_000
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              hold,
    input  logic              mux_bit,
    output logic [SEL_W-1:0]  sel,
    output logic              step_valid,
    output logic [NUM_IN-1:0] captured,
    output logic              busy,
    output logic              done
);

    state_t            state_reg;
    state_t            state_next;
    logic [SEL_W-1:0]  sel_reg;
    logic [SEL_W-1:0]  sel_next;
    logic [NUM_IN-1:0] captured_reg;
    logic [NUM_IN-1:0] captured_next;
    logic              busy_reg;
    logic              busy_next;
    logic              done_reg;
    logic              done_next;
    logic              step_valid_reg;
    logic              step_valid_next;

    logic tick;
    logic accept;
    logic sample;
    logic last_step;

    assign accept    = (state_reg == IDLE) && start;
    assign sample    = (state_reg == SCAN) && tick;
    assign last_step = (sel_reg == SEL_W'(NUM_IN - 1));

    // busy_reg is high exactly while scanning, so it doubles as the divider enable.
    rate_tick #(
        .DIV (DIV)
    ) u_rate_tick (
        .clk  (clock),
        .srst (reset),
        .clr  (accept),
        .en   (busy_reg && !hold),
        .tick (tick)
    );

    // Each capture bit clears on an accepted start and loads only on its own step.
    for (genvar gi = 0; gi < NUM_IN; gi++) begin : g_capture
        assign captured_next[gi] = accept ? 1'b0 :
                                   (sample && sel_reg == SEL_W'(gi)) ? mux_bit :
                                   captured_reg[gi];
    end

    always_comb begin
        state_next      = state_reg;
        sel_next        = sel_reg;
        busy_next       = busy_reg;
        done_next       = 1'b0;
        step_valid_next = 1'b0;
        unique case (state_reg)
            IDLE: begin
                if (accept) begin
                    state_next = SCAN;
                    sel_next   = '0;
                    busy_next  = 1'b1;
                end
            end
            SCAN: begin
                if (sample) begin
                    step_valid_next = 1'b1;
                    if (last_step) begin
                        state_next = DONE;
                        busy_next  = 1'b0;
                        done_next  = 1'b1;
                    end else begin
                        sel_next = sel_reg + SEL_W'(1);
                    end
                end
            end
            DONE: begin
                state_next = IDLE;
                sel_next   = '0;
            end
            default: begin
                state_next = IDLE;
                sel_next   = '0;
                busy_next  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= IDLE;
            sel_reg        <= '0;
            captured_reg   <= '0;
            busy_reg       <= 1'b0;
            done_reg       <= 1'b0;
            step_valid_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            sel_reg        <= sel_next;
            captured_reg   <= captured_next;
            busy_reg       <= busy_next;
            done_reg       <= done_next;
            step_valid_reg <= step_valid_next;
        end
    end

    assign sel        = sel_reg;
    assign step_valid = step_valid_reg;
    assign captured   = captured_reg;
    assign busy       = busy_reg;
    assign done       = done_reg;

endmodule

// File: tb/tb_mux_sel_scanner.sv
// Drives three scanners (DIV = 1, 2, 3) and compares every cycle against a
// progress-count model: p non-held scan cycles imply sel = p/DIV.
module tb_mux_sel_scanner;

    logic       clock = 1'b0;
    logic       reset;
    logic [2:0] start;
    logic [2:0] hold;
    logic [2:0] mux_bit;
    logic [2:0] step_valid;
    logic [2:0] busy;
    logic [2:0] done;
    logic [2:0] sel [3];
    logic [6:0] captured [3];
    logic [6:0] pat [3];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        logic [7:0] pat_ext;
        assign pat_ext     = {1'b0, pat[gi]};
        assign mux_bit[gi] = pat_ext[sel[gi]];

        mux_sel_scanner #(
            .DIV (gi + 1)
        ) u_dut (
            .clock      (clock),
            .reset      (reset),
            .start      (start[gi]),
            .hold       (hold[gi]),
            .mux_bit    (mux_bit[gi]),
            .sel        (sel[gi]),
            .step_valid (step_valid[gi]),
            .captured   (captured[gi]),
            .busy       (busy[gi]),
            .done       (done[gi])
        );
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input int d, input int c, input int e_sel, input int e_sv,
                             input int e_done, input int e_busy, input logic [6:0] e_cap);
        string pfx;
        pfx = $sformatf("d%0d_c%0d", d, c);
        check({pfx, "_sel"},  32'(sel[d]),        32'(e_sel));
        check({pfx, "_sv"},   32'(step_valid[d]), 32'(e_sv));
        check({pfx, "_done"}, 32'(done[d]),       32'(e_done));
        check({pfx, "_busy"}, 32'(busy[d]),       32'(e_busy));
        check({pfx, "_cap"},  32'(captured[d]),   32'(e_cap));
    endtask

    // hold_mode: 0 none, 1 window [hs, hs+hl), 2 random per edge.
    // xs1/xs2: edge indices (relative to the start edge) carrying a stray start pulse.
    task automatic run_scan(input int d, input logic [6:0] p_in, input int hold_mode,
                            input int hs, input int hl, input int xs1, input int xs2,
                            input int abort_c, input bit keep_start,
                            output int done_c, output int done_abs);
        int div;
        int total;
        int p;
        int c;
        int n;
        bit h;
        div      = d + 1;
        total    = 7 * div;
        done_c   = -1;
        done_abs = -1;
        pat[d]   = p_in;
        start[d] = 1'b1;
        hold[d]  = (hold_mode == 2) ? ($urandom_range(0, 1) == 1) : 1'b0;
        @(posedge clock); #1;
        if (!keep_start) start[d] = 1'b0;
        p = 0;
        c = 0;
        check_all(d, c, 0, 0, 0, 1, 7'h00);
        while (1) begin
            c++;
            if (hold_mode == 1)      h = (c >= hs) && (c < hs + hl);
            else if (hold_mode == 2) h = ($urandom_range(0, 3) == 0);
            else                     h = 1'b0;
            hold[d] = h;
            if (c == xs1 || c == xs2) start[d] = 1'b1;
            else if (!keep_start)     start[d] = 1'b0;
            if (c == abort_c) reset = 1'b1;
            @(posedge clock); #1;
            if (reset) begin
                reset    = 1'b0;
                hold[d]  = 1'b0;
                start[d] = 1'b0;
                check_all(d, c, 0, 0, 0, 0, 7'h00);
                $display("scan dut=%0d div=%0d pat=%b aborted at cycle %0d", d, div, p_in, c);
                return;
            end
            if (!h) p++;
            if (p == total) begin
                check_all(d, c, 6, 1, 1, 0, p_in);
                done_c   = c;
                done_abs = cyc;
                break;
            end
            if (c > 2000) begin
                check("scan_timeout", 32'(c), 32'(total));
                break;
            end
            n = p / div;
            check_all(d, c, n, (!h && p % div == 0) ? 1 : 0, 0, 1, p_in & 7'((1 << n) - 1));
        end
        // DONE cycle: the following edge returns to IDLE regardless of hold/start.
        c++;
        hold[d] = ($urandom_range(0, 1) == 1);
        if (c == xs1 || c == xs2) start[d] = 1'b1;
        else if (!keep_start)     start[d] = 1'b0;
        @(posedge clock); #1;
        check_all(d, c, 0, 0, 0, 0, p_in);
        hold[d] = 1'b0;
        if (!keep_start) begin
            start[d] = 1'b0;
            @(posedge clock); #1;
            check_all(d, c + 1, 0, 0, 0, 0, p_in);
        end
        $display("scan dut=%0d div=%0d pat=%b done_cycle=%0d", d, div, p_in, done_c);
    endtask

    initial begin
        int dc;
        int da;
        int prev_da;
        int d;
        int tot;
        reset = 1'b1;
        start = '0;
        hold  = '0;
        for (int i = 0; i < 3; i++) pat[i] = 7'h00;
        repeat (3) @(posedge clock);
        #1;
        for (int i = 0; i < 3; i++) check_all(i, -1, 0, 0, 0, 0, 7'h00);
        reset = 1'b0;
        @(posedge clock); #1;

        // Basic DIV=2 scan with a fixed pattern.
        run_scan(1, 7'b1011001, 0, 0, 0, -1, -1, -1, 1'b0, dc, da);
        check("t1_scan_len", 32'(dc), 32'd14);

        // DIV=1, all ones then all zeros.
        run_scan(0, 7'h7F, 0, 0, 0, -1, -1, -1, 1'b0, dc, da);
        check("t2a_scan_len", 32'(dc), 32'd7);
        run_scan(0, 7'h00, 0, 0, 0, -1, -1, -1, 1'b0, dc, da);
        check("t2b_scan_len", 32'(dc), 32'd7);

        // DIV=3, hold for five edges while sel==3.
        run_scan(2, 7'b0110101, 1, 10, 5, -1, -1, -1, 1'b0, dc, da);
        check("t3_scan_len", 32'(dc), 32'd26);

        // DIV=2, stray starts at sel==4 and in the DONE cycle.
        run_scan(1, 7'b1100110, 0, 0, 0, 9, 15, -1, 1'b0, dc, da);
        check("t4_scan_len", 32'(dc), 32'd14);

        // DIV=2, reset at sel==5 aborts; then a normal scan follows.
        run_scan(1, 7'b1111111, 0, 0, 0, -1, -1, 11, 1'b0, dc, da);
        check("t5_abort_done", 32'(dc), 32'hFFFF_FFFF);
        run_scan(1, 7'b0101010, 0, 0, 0, -1, -1, -1, 1'b0, dc, da);
        check("t5_rescan_len", 32'(dc), 32'd14);

        // DIV=1, start held high: done every 9 cycles.
        prev_da = -1;
        for (int k = 0; k < 4; k++) begin
            run_scan(0, 7'($urandom), 0, 0, 0, -1, -1, -1, 1'b1, dc, da);
            if (k > 0) check("t6_done_period", 32'(da - prev_da), 32'd9);
            prev_da = da;
        end
        start[0] = 1'b0;
        @(posedge clock); #1;
        check_all(0, 99, 0, 0, 0, 0, captured[0] === captured[0] ? captured[0] : 7'h00);

        // Randomized scans with random holds and stray start pulses.
        for (int k = 0; k < 8; k++) begin
            d   = $urandom_range(0, 2);
            tot = 7 * (d + 1);
            run_scan(d, 7'($urandom), 2, 0, 0, $urandom_range(1, tot - 1),
                     ($urandom_range(0, 1) == 1) ? tot + 1 : -1, -1, 1'b0, dc, da);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
